// File: rtl/mem_arbiter_if.sv
// Bundle of the instruction port, data port and memory-side signals of mem_arbiter.
// The slave modport is the arbiter's view; the master modport is the requesters' and memory's view.
interface mem_arbiter_if;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt;
    logic        if_rvalid;
    logic [31:0] if_rdata;
    logic        if_err;

    logic        d_req;
    logic        d_wr;
    logic [1:0]  d_size;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_gnt;
    logic        d_rvalid;
    logic [31:0] d_rdata;
    logic        d_err;

    logic [31:0] mem_addr;
    logic [3:0]  mem_write;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    modport slave (
        input  if_req, if_addr, d_req, d_wr, d_size, d_addr, d_wdata, mem_rdata,
        output if_gnt, if_rvalid, if_rdata, if_err,
        output d_gnt, d_rvalid, d_rdata, d_err,
        output mem_addr, mem_write, mem_wdata
    );

    modport master (
        output if_req, if_addr, d_req, d_wr, d_size, d_addr, d_wdata, mem_rdata,
        input  if_gnt, if_rvalid, if_rdata, if_err,
        input  d_gnt, d_rvalid, d_rdata, d_err,
        input  mem_addr, mem_write, mem_wdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port (instruction/data) arbiter in front of a single-cycle-latency memory.
// state   | meaning
// IDLE    | grants at most one request per cycle
// WR_GAP  | one dead cycle after a legal store so a following read sees the new data
module mem_arbiter #(
    parameter int RR_EN     = 1,
    parameter int MEM_BYTES = 512
) (
    input  logic i_clk,
    input  logic i_reset,
    mem_arbiter_if.slave bus
);
    typedef enum logic {ST_IDLE, ST_WR_GAP} state_t;

    state_t r_state;
    logic   r_last_d;
    logic   r_if_rvalid;
    logic   r_if_err;
    logic   r_d_rvalid;
    logic   r_d_err;

    logic w_if_err;
    logic w_d_err;
    logic w_idle;
    logic w_pick_d;
    logic w_if_gnt;
    logic w_d_gnt;
    logic w_d_store;

    assign w_if_err = (bus.if_addr >= 32'(MEM_BYTES)) || (bus.if_addr[1:0] != 2'b00);

    always_comb begin
        w_d_err = (bus.d_addr >= 32'(MEM_BYTES));
        case (bus.d_size)
            2'd1:    w_d_err = w_d_err || (bus.d_addr[1:0] != 2'b00);
            2'd2:    w_d_err = w_d_err || bus.d_addr[0];
            2'd3:    w_d_err = w_d_err;
            default: w_d_err = 1'b1;
        endcase
    end

    // On a tie the data port wins unless round-robin says the instruction port is due.
    assign w_idle    = (r_state == ST_IDLE) && !i_reset;
    assign w_pick_d  = bus.d_req && (!bus.if_req || (RR_EN == 0) || !r_last_d);
    assign w_if_gnt  = w_idle && bus.if_req && !w_pick_d;
    assign w_d_gnt   = w_idle && w_pick_d;
    assign w_d_store = w_d_gnt && bus.d_wr && !w_d_err;

    always_comb begin
        bus.mem_addr  = 32'd0;
        bus.mem_wdata = 32'd0;
        bus.mem_write = 4'd0;
        if (w_if_gnt) begin
            bus.mem_addr  = bus.if_addr;
            bus.mem_wdata = bus.d_wdata;
        end else if (w_d_gnt) begin
            bus.mem_addr  = bus.d_addr;
            bus.mem_wdata = bus.d_wdata;
            bus.mem_write = w_d_store ? {2'b00, bus.d_size} : 4'd0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state     <= ST_IDLE;
            r_last_d    <= 1'b1;
            r_if_rvalid <= 1'b0;
            r_if_err    <= 1'b0;
            r_d_rvalid  <= 1'b0;
            r_d_err     <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE:   r_state <= w_d_store ? ST_WR_GAP : ST_IDLE;
                ST_WR_GAP: r_state <= ST_IDLE;
                default:   r_state <= ST_IDLE;
            endcase
            if (w_if_gnt)
                r_last_d <= 1'b0;
            else if (w_d_gnt)
                r_last_d <= 1'b1;
            r_if_rvalid <= w_if_gnt;
            r_if_err    <= w_if_gnt && w_if_err;
            r_d_rvalid  <= w_d_gnt && (!bus.d_wr || w_d_err);
            r_d_err     <= w_d_gnt && w_d_err;
        end
    end

    // Responses are masked while reset is high so a read granted just before reset never completes.
    assign bus.if_gnt    = w_if_gnt;
    assign bus.d_gnt     = w_d_gnt;
    assign bus.if_rvalid = r_if_rvalid && !i_reset;
    assign bus.if_err    = r_if_err && !i_reset;
    assign bus.if_rdata  = (r_if_rvalid && !r_if_err && !i_reset) ? bus.mem_rdata : 32'd0;
    assign bus.d_rvalid  = r_d_rvalid && !i_reset;
    assign bus.d_err     = r_d_err && !i_reset;
    assign bus.d_rdata   = (r_d_rvalid && !r_d_err && !i_reset) ? bus.mem_rdata : 32'd0;
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: round-robin, stores, errors, fixed priority and reset behaviour.
// A second instance with RR_EN=0 covers fixed data-port priority.
module tb_mem_arbiter;
    logic clk;
    logic rst;
    int   n_cmp;
    int   n_bad;

    logic [31:0] mem [128];

    mem_arbiter_if bus ();
    mem_arbiter_if bus2 ();

    mem_arbiter #(.RR_EN(1), .MEM_BYTES(512)) dut (
        .i_clk   (clk),
        .i_reset (rst),
        .bus     (bus.slave)
    );

    mem_arbiter #(.RR_EN(0), .MEM_BYTES(512)) dut2 (
        .i_clk   (clk),
        .i_reset (rst),
        .bus     (bus2.slave)
    );

    assign bus2.mem_rdata = 32'd0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: one-cycle read latency, byte lanes selected by the low address bits.
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 128; i++) mem[i] = 32'(i + 12);
        end else begin
            case (bus.mem_write)
                4'd1: mem[bus.mem_addr[8:2]] = bus.mem_wdata;
                4'd2: if (bus.mem_addr[1]) mem[bus.mem_addr[8:2]][31:16] = bus.mem_wdata[15:0];
                      else                 mem[bus.mem_addr[8:2]][15:0]  = bus.mem_wdata[15:0];
                4'd3: mem[bus.mem_addr[8:2]][8*bus.mem_addr[1:0] +: 8] = bus.mem_wdata[7:0];
                default: ;
            endcase
        end
        bus.mem_rdata <= mem[bus.mem_addr[8:2]];
    end

    task automatic idle_inputs();
        bus.if_req = 1'b0; bus.if_addr = 32'd0;
        bus.d_req = 1'b0;  bus.d_wr = 1'b0; bus.d_size = 2'd1;
        bus.d_addr = 32'd0; bus.d_wdata = 32'd0;
        bus2.if_req = 1'b0; bus2.if_addr = 32'd0;
        bus2.d_req = 1'b0;  bus2.d_wr = 1'b0; bus2.d_size = 2'd1;
        bus2.d_addr = 32'd0; bus2.d_wdata = 32'd0;
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        step();
        bus.if_req = 1'b1; bus.if_addr = 32'h10;
        bus.d_req = 1'b1;  bus.d_addr = 32'h20;
        #1;
        n_cmp++;
        if (bus.if_gnt !== 1'b0 || bus.d_gnt !== 1'b0) begin
            n_bad++; $display("FAIL reset_gnt got if=%b d=%b want 0 0", bus.if_gnt, bus.d_gnt);
        end
        n_cmp++;
        if (bus.mem_write !== 4'd0 || bus.if_rvalid !== 1'b0 || bus.d_rvalid !== 1'b0) begin
            n_bad++; $display("FAIL reset_outputs got wr=%0d ifv=%b dv=%b want 0 0 0",
                              bus.mem_write, bus.if_rvalid, bus.d_rvalid);
        end
        step();
        idle_inputs();
        rst = 1'b0;
        step();
    endtask

    task automatic test_round_robin();
        logic want_if;
        logic prev_if;
        bus.if_req = 1'b1; bus.if_addr = 32'h10;
        bus.d_req = 1'b1;  bus.d_wr = 1'b0; bus.d_size = 2'd1; bus.d_addr = 32'h20;
        #1;
        for (int k = 0; k < 6; k++) begin
            want_if = (k % 2 == 0);
            n_cmp++;
            if (bus.if_gnt !== want_if || bus.d_gnt !== !want_if) begin
                n_bad++; $display("FAIL rr_gnt k=%0d got if=%b d=%b want if=%b d=%b",
                                  k, bus.if_gnt, bus.d_gnt, want_if, !want_if);
            end
            n_cmp++;
            if (bus.mem_addr !== (want_if ? 32'h10 : 32'h20)) begin
                n_bad++; $display("FAIL rr_mem_addr k=%0d got %h", k, bus.mem_addr);
            end
            if (k > 0) begin
                prev_if = !want_if;
                n_cmp++;
                if (bus.if_rvalid !== prev_if || bus.d_rvalid !== !prev_if) begin
                    n_bad++; $display("FAIL rr_rvalid k=%0d got if=%b d=%b want if=%b d=%b",
                                      k, bus.if_rvalid, bus.d_rvalid, prev_if, !prev_if);
                end
                n_cmp++;
                if (bus.if_rdata !== (prev_if ? 32'd16 : 32'd0) ||
                    bus.d_rdata  !== (prev_if ? 32'd0 : 32'd20)) begin
                    n_bad++; $display("FAIL rr_rdata k=%0d got if=%h d=%h", k, bus.if_rdata, bus.d_rdata);
                end
            end
            step();
        end
        idle_inputs();
        #1;
        n_cmp++;
        if (bus.d_rvalid !== 1'b1 || bus.d_rdata !== 32'd20 || bus.if_rvalid !== 1'b0) begin
            n_bad++; $display("FAIL rr_last got dv=%b d=%h ifv=%b want 1 00000014 0",
                              bus.d_rvalid, bus.d_rdata, bus.if_rvalid);
        end
        step();
    endtask

    task automatic test_store_then_read();
        bus.d_req = 1'b1; bus.d_wr = 1'b1; bus.d_size = 2'd1;
        bus.d_addr = 32'h40; bus.d_wdata = 32'hDEADBEEF;
        #1;
        n_cmp++;
        if (bus.d_gnt !== 1'b1 || bus.mem_write !== 4'd1 || bus.mem_addr !== 32'h40) begin
            n_bad++; $display("FAIL st_word_grant got gnt=%b wr=%0d addr=%h want 1 1 40",
                              bus.d_gnt, bus.mem_write, bus.mem_addr);
        end
        step();
        idle_inputs();
        bus.if_req = 1'b1; bus.if_addr = 32'h40;
        #1;
        n_cmp++;
        if (bus.if_gnt !== 1'b0 || bus.d_rvalid !== 1'b0) begin
            n_bad++; $display("FAIL st_gap got if_gnt=%b d_rvalid=%b want 0 0", bus.if_gnt, bus.d_rvalid);
        end
        step();
        n_cmp++;
        if (bus.if_gnt !== 1'b1) begin
            n_bad++; $display("FAIL st_read_grant got %b want 1", bus.if_gnt);
        end
        step();
        idle_inputs();
        #1;
        n_cmp++;
        if (bus.if_rvalid !== 1'b1 || bus.if_err !== 1'b0 || bus.if_rdata !== 32'hDEADBEEF) begin
            n_bad++; $display("FAIL st_readback got v=%b e=%b d=%h want 1 0 deadbeef",
                              bus.if_rvalid, bus.if_err, bus.if_rdata);
        end
        step();
    endtask

    task automatic test_byte_store();
        bus.d_req = 1'b1; bus.d_wr = 1'b1; bus.d_size = 2'd3;
        bus.d_addr = 32'h44; bus.d_wdata = 32'h12345678;
        #1;
        n_cmp++;
        if (bus.d_gnt !== 1'b1 || bus.mem_write !== 4'd3) begin
            n_bad++; $display("FAIL byte_grant got gnt=%b wr=%0d want 1 3", bus.d_gnt, bus.mem_write);
        end
        step();
        idle_inputs();
        step();
        bus.d_req = 1'b1; bus.d_wr = 1'b0; bus.d_size = 2'd1; bus.d_addr = 32'h44;
        #1;
        n_cmp++;
        if (bus.d_gnt !== 1'b1) begin
            n_bad++; $display("FAIL byte_read_grant got %b want 1", bus.d_gnt);
        end
        step();
        idle_inputs();
        #1;
        n_cmp++;
        if (bus.d_rvalid !== 1'b1 || bus.d_rdata !== 32'h00000078) begin
            n_bad++; $display("FAIL byte_readback got v=%b d=%h want 1 00000078", bus.d_rvalid, bus.d_rdata);
        end
        step();
    endtask

    task automatic test_errors();
        logic [31:0] e_addr [3];
        logic        e_wr   [3];
        logic [1:0]  e_size [3];
        e_addr = '{32'h200, 32'h42, 32'h40};
        e_wr   = '{1'b0, 1'b1, 1'b0};
        e_size = '{2'd1, 2'd1, 2'd0};
        for (int k = 0; k < 3; k++) begin
            bus.d_req = 1'b1; bus.d_wr = e_wr[k]; bus.d_size = e_size[k];
            bus.d_addr = e_addr[k]; bus.d_wdata = 32'h0BADF00D;
            #1;
            n_cmp++;
            if (bus.d_gnt !== 1'b1 || bus.mem_write !== 4'd0) begin
                n_bad++; $display("FAIL err_grant k=%0d got gnt=%b wr=%0d want 1 0", k, bus.d_gnt, bus.mem_write);
            end
            step();
            idle_inputs();
            #1;
            n_cmp++;
            if (bus.d_rvalid !== 1'b1 || bus.d_err !== 1'b1 || bus.d_rdata !== 32'd0) begin
                n_bad++; $display("FAIL err_resp k=%0d got v=%b e=%b d=%h want 1 1 0",
                                  k, bus.d_rvalid, bus.d_err, bus.d_rdata);
            end
        end
        bus.if_req = 1'b1; bus.if_addr = 32'h12;
        #1;
        n_cmp++;
        if (bus.if_gnt !== 1'b1 || bus.mem_write !== 4'd0) begin
            n_bad++; $display("FAIL if_err_grant got gnt=%b wr=%0d want 1 0", bus.if_gnt, bus.mem_write);
        end
        step();
        idle_inputs();
        bus.d_req = 1'b1; bus.d_wr = 1'b0; bus.d_size = 2'd1; bus.d_addr = 32'h40;
        #1;
        n_cmp++;
        if (bus.if_rvalid !== 1'b1 || bus.if_err !== 1'b1 || bus.if_rdata !== 32'd0) begin
            n_bad++; $display("FAIL if_err_resp got v=%b e=%b d=%h want 1 1 0",
                              bus.if_rvalid, bus.if_err, bus.if_rdata);
        end
        step();
        idle_inputs();
        #1;
        n_cmp++;
        if (bus.d_rvalid !== 1'b1 || bus.d_err !== 1'b0 || bus.d_rdata !== 32'hDEADBEEF) begin
            n_bad++; $display("FAIL err_mem_unchanged got v=%b e=%b d=%h want 1 0 deadbeef",
                              bus.d_rvalid, bus.d_err, bus.d_rdata);
        end
        step();
    endtask

    task automatic test_fixed_priority();
        bus2.if_req = 1'b1; bus2.if_addr = 32'h10;
        bus2.d_req = 1'b1;  bus2.d_wr = 1'b0; bus2.d_size = 2'd1; bus2.d_addr = 32'h20;
        #1;
        for (int k = 0; k < 4; k++) begin
            n_cmp++;
            if (bus2.d_gnt !== 1'b1 || bus2.if_gnt !== 1'b0) begin
                n_bad++; $display("FAIL fixed_prio k=%0d got if=%b d=%b want 0 1", k, bus2.if_gnt, bus2.d_gnt);
            end
            step();
        end
        idle_inputs();
        step();
    endtask

    task automatic test_back_to_back_reset();
        bus.if_req = 1'b1; bus.if_addr = 32'h10;
        #1;
        n_cmp++;
        if (bus.if_gnt !== 1'b1) begin
            n_bad++; $display("FAIL rst_pre_grant got %b want 1", bus.if_gnt);
        end
        step();
        rst = 1'b1;
        bus.d_req = 1'b1; bus.d_addr = 32'h20;
        #1;
        n_cmp++;
        if (bus.if_rvalid !== 1'b0 || bus.if_gnt !== 1'b0 || bus.d_gnt !== 1'b0) begin
            n_bad++; $display("FAIL rst_suppress got v=%b ifg=%b dg=%b want 0 0 0",
                              bus.if_rvalid, bus.if_gnt, bus.d_gnt);
        end
        step();
        rst = 1'b0;
        #1;
        n_cmp++;
        if (bus.if_rvalid !== 1'b0 || bus.if_gnt !== 1'b1 || bus.d_gnt !== 1'b0) begin
            n_bad++; $display("FAIL rst_first_tie got v=%b ifg=%b dg=%b want 0 1 0",
                              bus.if_rvalid, bus.if_gnt, bus.d_gnt);
        end
        step();
        idle_inputs();
        #1;
        n_cmp++;
        if (bus.if_rvalid !== 1'b1 || bus.if_rdata !== 32'd16) begin
            n_bad++; $display("FAIL rst_post_read got v=%b d=%h want 1 00000010", bus.if_rvalid, bus.if_rdata);
        end
        step();
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst = 1'b1;
        idle_inputs();
        step();
        test_reset();
        test_round_robin();
        test_store_then_read();
        test_byte_store();
        test_errors();
        test_fixed_priority();
        test_back_to_back_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
